// File: rtl/instruction_decode_ctrl.sv
// Fetch/decode/execute control FSM for the ALU/register-bank datapath: fetches, decodes, evaluates branches.
// Optional build macro INSTR_COUNT_EN adds the retired_count output (instructions retired).
module instruction_decode_ctrl #(
    parameter int PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [15:0]         instr_data,
    input  logic                instr_valid,
    input  logic [4:0]          flagsOutput,
    output logic [15:0]         immediate,
    output logic [4:0]          regEnables,
    output logic [4:0]          buffAEnables,
    output logic [4:0]          buffBEnables,
    output logic                Cin,
    output logic                regOrImmed,
    output logic [3:0]          op,
    output logic [3:0]          exop,
    output logic                halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]         retired_count
`endif
);

    typedef enum logic [1:0] {Fetch, Decode, Execute, Halt} stateT;

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    stateT               state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic [3:0]          irOp;

    logic [4:0]  decA;
    logic [4:0]  decB;
    logic [4:0]  decW;
    logic [3:0]  decOp;
    logic [3:0]  decExop;
    logic [15:0] decImm;
    logic        decRoi;

    logic [PC_WIDTH-1:0] branchDisp;
    logic [PC_WIDTH-1:0] nextPc;

    // Flags are {N,Z,F,L,C} at bits {4,3,2,1,0}.
    function automatic logic branchTaken(input logic [3:0] cond, input logic [4:0] f);
        logic taken;
        case (cond)
            4'h0:    taken = f[3];
            4'h1:    taken = ~f[3];
            4'h2:    taken = f[0];
            4'h3:    taken = ~f[0];
            4'h6:    taken = f[4];
            4'h7:    taken = ~f[4];
            4'h8:    taken = f[2];
            4'h9:    taken = ~f[2];
            4'hC:    taken = f[1];
            4'hD:    taken = ~f[1];
            4'hE:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign irOp       = ir[15:12];
    assign instr_addr = pc;
    assign Cin        = flagsOutput[0];

    always_comb begin
        decA    = '0;
        decB    = '0;
        decW    = '0;
        decOp   = '0;
        decExop = '0;
        decImm  = '0;
        decRoi  = 1'b1;
        case (irOp)
            4'h0: begin
                decA    = {1'b1, ir[11:8]};
                decB    = {1'b1, ir[3:0]};
                decW    = {1'b1, ir[11:8]};
                decExop = ir[7:4];
            end
            4'hC: decOp = 4'hC;
            4'hF: decOp = 4'h0;
            default: begin
                decA   = {1'b1, ir[11:8]};
                decW   = {1'b1, ir[11:8]};
                decOp  = irOp;
                decRoi = 1'b0;
                // Logical-style ops 1..3 take an unsigned byte; everything else is signed.
                decImm = (irOp inside {4'h1, 4'h2, 4'h3}) ? {8'h00, ir[7:0]}
                                                          : {{8{ir[7]}}, ir[7:0]};
            end
        endcase
    end

    assign branchDisp = {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};
    assign nextPc = (irOp == 4'hC && branchTaken(ir[11:8], flagsOutput)) ? pc + branchDisp
                                                                        : pc + PC_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= Fetch;
            pc           <= RESET_PC;
            ir           <= '0;
            instr_req    <= 1'b0;
            halted       <= 1'b0;
            immediate    <= '0;
            regEnables   <= '0;
            buffAEnables <= '0;
            buffBEnables <= '0;
            regOrImmed   <= 1'b1;
            op           <= '0;
            exop         <= '0;
`ifdef INSTR_COUNT_EN
            retired_count <= '0;
`endif
        end else begin
            case (state)
                Fetch: begin
                    // The first cycle after reset only raises the request.
                    if (!instr_req) begin
                        instr_req <= 1'b1;
                    end else if (instr_valid) begin
                        ir        <= instr_data;
                        instr_req <= 1'b0;
                        state     <= Decode;
                    end
                end
                Decode: begin
                    immediate    <= decImm;
                    regEnables   <= decW;
                    buffAEnables <= decA;
                    buffBEnables <= decB;
                    regOrImmed   <= decRoi;
                    op           <= decOp;
                    exop         <= decExop;
                    state        <= Execute;
                end
                Execute: begin
                    pc           <= nextPc;
                    immediate    <= '0;
                    regEnables   <= '0;
                    buffAEnables <= '0;
                    buffBEnables <= '0;
                    regOrImmed   <= 1'b1;
                    op           <= '0;
                    exop         <= '0;
`ifdef INSTR_COUNT_EN
                    retired_count <= retired_count + 16'd1;
`endif
                    if (irOp == 4'hF) begin
                        halted <= 1'b1;
                        state  <= Halt;
                    end else begin
                        instr_req <= 1'b1;
                        state     <= Fetch;
                    end
                end
                default: state <= Halt;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decode_ctrl.sv
// Randomized self-checking bench for instruction_decode_ctrl against a transaction-level model.
module tb_instruction_decode_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr_data = '0;
    logic        instr_valid = 1'b0;
    logic [4:0]  flagsOutput = '0;

    logic        instr_req, Cin, regOrImmed, halted;
    logic [15:0] instr_addr, immediate;
    logic [4:0]  regEnables, buffAEnables, buffBEnables;
    logic [3:0]  op, exop;

    logic        reqW, cinW, roiW, haltedW;
    logic [15:0] addrW, immW;
    logic [4:0]  regW, buffAW, buffBW;
    logic [3:0]  opW, exopW;
`ifdef INSTR_COUNT_EN
    logic [15:0] retired0, retired1;
`endif

    int nChecks = 0;
    int nPass = 0;
    logic [15:0] mPc = 16'h0000;
    int mCount = 0;

    always #5 clock = ~clock;

    instruction_decode_ctrl #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_data(instr_data), .instr_valid(instr_valid), .flagsOutput(flagsOutput),
        .immediate(immediate), .regEnables(regEnables), .buffAEnables(buffAEnables),
        .buffBEnables(buffBEnables), .Cin(Cin), .regOrImmed(regOrImmed), .op(op),
        .exop(exop), .halted(halted)
`ifdef INSTR_COUNT_EN
        , .retired_count(retired0)
`endif
    );

    // Second instance starts at the top of the address space; it tracks the first one minus 1.
    instruction_decode_ctrl #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dutWrap (
        .clock(clock), .reset(reset), .instr_req(reqW), .instr_addr(addrW),
        .instr_data(instr_data), .instr_valid(instr_valid), .flagsOutput(flagsOutput),
        .immediate(immW), .regEnables(regW), .buffAEnables(buffAW),
        .buffBEnables(buffBW), .Cin(cinW), .regOrImmed(roiW), .op(opW),
        .exop(exopW), .halted(haltedW)
`ifdef INSTR_COUNT_EN
        , .retired_count(retired1)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit modelTaken(input logic [3:0] cond, input logic [4:0] fl);
        bit n = fl[4];
        bit z = fl[3];
        bit f = fl[2];
        bit l = fl[1];
        bit c = fl[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hC: return l;
            4'hD: return !l;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "RegEn"}, 32'(regEnables), 0);
        checkVal({tag, "BuffA"}, 32'(buffAEnables), 0);
        checkVal({tag, "BuffB"}, 32'(buffBEnables), 0);
        checkVal({tag, "Roi"}, 32'(regOrImmed), 1);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        instr_valid = 1'b0;
        tick();
        checkVal("rstReq", 32'(instr_req), 0);
        checkVal("rstAddr", 32'(instr_addr), 0);
        checkVal("rstWrapAddr", 32'(addrW), 'hFFFF);
        checkVal("rstHalted", 32'(halted), 0);
        checkIdle("rst");
        mPc = 16'h0000;
        mCount = 0;
`ifdef INSTR_COUNT_EN
        checkVal("rstCount", 32'(retired0), 0);
`endif
        reset = 1'b0;
        tick();
        checkVal("postRstReq", 32'(instr_req), 1);
    endtask

    task automatic runInstr(input logic [15:0] instr, input logic [4:0] flg, input int waits);
        logic [3:0] opc;
        logic [15:0] expImm;
        bit isHalt;
        int disp;
        opc = instr[15:12];
        isHalt = (opc == 4'hF);
        flagsOutput = flg;
        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr_data = 16'($urandom);
            tick();
            checkVal("waitReq", 32'(instr_req), 1);
            checkVal("waitAddr", 32'(instr_addr), 32'(mPc));
            checkIdle("wait");
        end
        instr_valid = 1'b1;
        instr_data = instr;
        tick();
        instr_valid = 1'($urandom);
        instr_data = 16'($urandom);
        checkVal("decReq", 32'(instr_req), 0);
        checkIdle("dec");
        tick();
        instr_valid = 1'($urandom);
        instr_data = 16'($urandom);
        checkVal("exeCin", 32'(Cin), 32'(flg[0]));
        if (opc == 4'h0) begin
            checkVal("regA", 32'(buffAEnables), 32'({1'b1, instr[11:8]}));
            checkVal("regB", 32'(buffBEnables), 32'({1'b1, instr[3:0]}));
            checkVal("regW", 32'(regEnables), 32'({1'b1, instr[11:8]}));
            checkVal("regOp", 32'(op), 0);
            checkVal("regExop", 32'(exop), 32'(instr[7:4]));
            checkVal("regRoi", 32'(regOrImmed), 1);
        end else if (opc == 4'hC || isHalt) begin
            checkVal("brA", 32'(buffAEnables), 0);
            checkVal("brB", 32'(buffBEnables), 0);
            checkVal("brW", 32'(regEnables), 0);
        end else begin
            if (opc >= 4'h1 && opc <= 4'h3) expImm = 16'(int'(instr[7:0]));
            else expImm = 16'(int'($signed(instr[7:0])));
            checkVal("immA", 32'(buffAEnables), 32'({1'b1, instr[11:8]}));
            checkVal("immB", 32'(buffBEnables), 0);
            checkVal("immW", 32'(regEnables), 32'({1'b1, instr[11:8]}));
            checkVal("immOp", 32'(op), 32'(opc));
            checkVal("immExop", 32'(exop), 0);
            checkVal("immRoi", 32'(regOrImmed), 0);
            checkVal("immVal", 32'(immediate), 32'(expImm));
        end
        if (opc == 4'hC && modelTaken(instr[11:8], flg)) disp = int'($signed(instr[7:0]));
        else disp = 1;
        mPc = 16'(int'(mPc) + disp);
        mCount++;
        tick();
        instr_valid = 1'b0;
        checkVal("nextAddr", 32'(instr_addr), 32'(mPc));
        checkVal("wrapAddr", 32'(addrW), 32'(16'(mPc - 16'd1)));
        checkVal("nextReq", 32'(instr_req), isHalt ? 0 : 1);
        checkVal("nextHalted", 32'(halted), isHalt ? 1 : 0);
        checkIdle("next");
`ifdef INSTR_COUNT_EN
        checkVal("count", 32'(retired0), 32'(16'(mCount)));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] instr;
        resetDut();

        runInstr(16'h0015, 5'b00001, 0);
        runInstr(16'h53F0, 5'b00000, 0);
        runInstr(16'h13F0, 5'b00000, 1);
        runInstr(16'hCE0D, 5'b00000, 0);
        checkVal("pcTo10", 32'(instr_addr), 'h10);
        runInstr(16'hC0FE, 5'b01000, 0);
        checkVal("beqTaken", 32'(instr_addr), 'h0E);
        runInstr(16'hCE02, 5'b00000, 0);
        runInstr(16'hC0FE, 5'b00000, 0);
        checkVal("beqNotTaken", 32'(instr_addr), 'h11);
        runInstr(16'h2345, 5'b10101, 4);

        // Reset in the middle of a fetch wait.
        instr_valid = 1'b0;
        tick();
        checkVal("midWaitReq", 32'(instr_req), 1);
        resetDut();

        for (int k = 0; k < 150; k++) begin
            instr = 16'($urandom);
            if (instr[15:12] == 4'hF) instr[15:12] = 4'hC;
            runInstr(instr, 5'($urandom), int'($urandom_range(0, 2)));
        end

        runInstr(16'hF000, 5'b00000, 0);
        for (int k = 0; k < 4; k++) begin
            instr_valid = 1'b1;
            instr_data = 16'h0015;
            tick();
            checkVal("haltStay", 32'(halted), 1);
            checkVal("haltReq", 32'(instr_req), 0);
            checkVal("haltAddr", 32'(instr_addr), 32'(mPc));
            checkIdle("halt");
        end
        resetDut();
        runInstr(16'h4A81, 5'b00000, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
